// File: rtl/toggle_counter_pkg.sv
// rtl/toggle_counter_pkg.sv - shared constants and sizing helper for toggle_counter
package toggle_counter_pkg;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_PRESCALE = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/toggle_counter_tff_cell.sv
// rtl/toggle_counter_tff_cell.sv - one counter bit: T flip-flop with sync clear and load
module tff_cell (
   input  logic CLK,
   input  logic RST_N,
   input  logic t,
   input  logic ld,
   input  logic d,
   input  logic clr,
   output logic q
);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)  q <= 1'b0;
      else if (clr) q <= 1'b0;
      else if (ld)  q <= d;
      else if (t)   q <= ~q;
   end

endmodule

// File: rtl/toggle_counter.sv
// rtl/toggle_counter.sv - up/down T-flip-flop counter with prescaler, terminal-count pulse and sticky overflow
module toggle_counter
   import toggle_counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             ovf
);

   localparam int PSW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

   logic [PSW-1:0] ps;
   logic           step;
   logic           wrap;
   logic [WIDTH:0] all_ones;
   logic [WIDTH:0] all_zeros;
   logic [WIDTH-1:0] t;

   assign step = en && (ps == PS_LAST);

   // Prefix terms: bit i toggles when every lower bit is 1 (up) or 0 (down);
   // the full-width term marks a wrapping step.
   always_comb begin
      all_ones  = '0;
      all_zeros = '0;
      all_ones[0]  = 1'b1;
      all_zeros[0] = 1'b1;
      for (int i = 1; i <= WIDTH; i++) begin
         all_ones[i]  = all_ones[i-1]  & Q[i-1];
         all_zeros[i] = all_zeros[i-1] & ~Q[i-1];
      end
   end

   always_comb begin
      t = '0;
      for (int i = 0; i < WIDTH; i++) begin
         t[i] = step & (up ? all_ones[i] : all_zeros[i]);
      end
   end

   assign wrap = step & (up ? all_ones[WIDTH] : all_zeros[WIDTH]);

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_bit
         tff_cell u_cell (
            .CLK   (CLK),
            .RST_N (RST_N),
            .t     (t[g]),
            .ld    (load),
            .d     (load_val[g]),
            .clr   (clr),
            .q     (Q[g])
         );
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ps  <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else if (clr) begin
         ps  <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else if (load) begin
         ps <= '0;
         tc <= 1'b0;
      end else if (en) begin
         ps <= step ? '0 : ps + PSW'(1);
         tc <= wrap;
         if (wrap) ovf <= 1'b1;
      end else begin
         tc <= 1'b0;
      end
   end

endmodule

// File: tb/tb_toggle_counter.sv
// tb/tb_toggle_counter.sv - self-checking bench for toggle_counter against an arithmetic reference model
module tb_toggle_counter;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'h0;

   logic [3:0] qa, qb;
   logic [0:0] qc;
   logic       tca, tcb, tcc;
   logic       ovfa, ovfb, ovfc;

   int total = 0;
   int bad = 0;

   int mq[3], mps[3], mtc[3], movf[3];
   int mw[3] = '{4, 4, 1};
   int mp[3] = '{1, 3, 1};

   always #5 CLK = ~CLK;

   toggle_counter #(.WIDTH(4), .PRESCALE(1)) u_a (
      .CLK(CLK), .RST_N(RST_N), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .Q(qa), .tc(tca), .ovf(ovfa));

   toggle_counter #(.WIDTH(4), .PRESCALE(3)) u_b (
      .CLK(CLK), .RST_N(RST_N), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .Q(qb), .tc(tcb), .ovf(ovfb));

   toggle_counter #(.WIDTH(1), .PRESCALE(1)) u_c (
      .CLK(CLK), .RST_N(RST_N), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val[0:0]), .Q(qc), .tc(tcc), .ovf(ovfc));

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mq[k] = 0; mps[k] = 0; mtc[k] = 0; movf[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         int m;
         m = 1 << mw[k];
         if (clr) begin
            mq[k] = 0; mps[k] = 0; mtc[k] = 0; movf[k] = 0;
         end else if (load) begin
            mq[k] = int'(load_val) % m; mps[k] = 0; mtc[k] = 0;
         end else if (en) begin
            if (mps[k] == mp[k] - 1) begin
               mps[k] = 0;
               if (up) begin
                  mq[k] = (mq[k] + 1) % m;
                  mtc[k] = (mq[k] == 0) ? 1 : 0;
               end else begin
                  mq[k] = (mq[k] + m - 1) % m;
                  mtc[k] = (mq[k] == m - 1) ? 1 : 0;
               end
               if (mtc[k] != 0) movf[k] = 1;
            end else begin
               mps[k] = mps[k] + 1;
               mtc[k] = 0;
            end
         end else begin
            mtc[k] = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      total++;
      assert (obs === 32'(exp))
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("a_q",   {28'b0, qa},   mq[0]);
      chk("a_tc",  {31'b0, tca},  mtc[0]);
      chk("a_ovf", {31'b0, ovfa}, movf[0]);
      chk("b_q",   {28'b0, qb},   mq[1]);
      chk("b_tc",  {31'b0, tcb},  mtc[1]);
      chk("b_ovf", {31'b0, ovfb}, movf[1]);
      chk("c_q",   {31'b0, qc},   mq[2]);
      chk("c_tc",  {31'b0, tcc},  mtc[2]);
      chk("c_ovf", {31'b0, ovfc}, movf[2]);
   endtask

   task automatic cyc(input logic e, input logic u, input logic c, input logic l, input logic [3:0] lv);
      en = e; up = u; clr = c; load = l; load_val = lv;
      @(posedge CLK);
      if (RST_N) model_edge();
      #1;
      chk_all();
   endtask

   initial begin
      model_reset();
      #2;
      chk_all();
      #10 RST_N = 1'b1;

      // async reset mid-count from Q=9, then first enabled edge gives 1
      cyc(0, 1, 0, 1, 4'h9);
      chk("load9", {28'b0, qa}, 9);
      #2 RST_N = 1'b0;
      #1 model_reset();
      chk_all();
      chk("rst_q_async", {28'b0, qa}, 0);
      #2 RST_N = 1'b1;
      cyc(1, 1, 0, 0, 4'h0);
      chk("rst_first_step", {28'b0, qa}, 1);

      // up wrap
      cyc(0, 1, 0, 1, 4'hE);
      cyc(1, 1, 0, 0, 4'h0);
      chk("upwrap_f", {28'b0, qa}, 15);
      cyc(1, 1, 0, 0, 4'h0);
      chk("upwrap_0", {28'b0, qa}, 0);
      chk("upwrap_tc", {31'b0, tca}, 1);
      cyc(1, 1, 0, 0, 4'h0);
      chk("upwrap_tc_low", {31'b0, tca}, 0);
      chk("upwrap_ovf", {31'b0, ovfa}, 1);

      // down wrap then clear
      cyc(0, 0, 0, 1, 4'h1);
      cyc(1, 0, 0, 0, 4'h0);
      cyc(1, 0, 0, 0, 4'h0);
      chk("dnwrap_f", {28'b0, qa}, 15);
      chk("dnwrap_tc", {31'b0, tca}, 1);
      cyc(0, 0, 1, 0, 4'h0);
      chk("clr_ovf", {31'b0, ovfa}, 0);

      // prescale by 3, with an en gap at prescaler=1
      for (int i = 0; i < 9; i++) cyc(1, 1, 0, 0, 4'h0);
      chk("pre_q3", {28'b0, qb}, 3);
      cyc(1, 1, 0, 0, 4'h0);
      cyc(0, 1, 0, 0, 4'h0);
      cyc(0, 1, 0, 0, 4'h0);
      chk("pre_hold", {28'b0, qb}, 3);
      cyc(1, 1, 0, 0, 4'h0);
      chk("pre_not_yet", {28'b0, qb}, 3);
      cyc(1, 1, 0, 0, 4'h0);
      chk("pre_step", {28'b0, qb}, 4);

      // priority: clr over load, load over step
      cyc(1, 1, 1, 1, 4'h7);
      chk("prio_clr", {28'b0, qa}, 0);
      cyc(1, 1, 0, 1, 4'h7);
      chk("prio_load", {28'b0, qa}, 7);
      cyc(1, 1, 0, 0, 4'h0);
      cyc(1, 1, 0, 0, 4'h0);
      chk("prio_ps_restart", {28'b0, qb}, 7);
      cyc(1, 1, 0, 0, 4'h0);
      chk("prio_ps_step", {28'b0, qb}, 8);

      // direction change each step
      cyc(0, 1, 1, 0, 4'h0);
      cyc(0, 1, 0, 1, 4'h5);
      for (int i = 0; i < 4; i++) cyc(1, (i % 2 == 0), 0, 0, 4'h0);
      chk("dir_q", {28'b0, qa}, 5);
      chk("dir_ovf", {31'b0, ovfa}, 0);

      // randomized traffic with occasional asynchronous reset
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(9) != 0), $urandom_range(1),
             ($urandom_range(39) == 0), ($urandom_range(11) == 0),
             4'($urandom_range(15)));
         if ($urandom_range(99) == 0) begin
            #2 RST_N = 1'b0;
            #1 model_reset();
            chk_all();
            #1 RST_N = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
